lbist_sched: RTL and testbench

LBIST_SCHED -- requirements
Module: lbist_sched

---
 rtl/lbist_pkg.sv | 19 +
 rtl/lbist_prio_enc.sv | 18 +
 rtl/lbist_sched.sv | 165 ++++++++++++++++
 tb/tb_lbist_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lbist_pkg.sv
// Shared types for the LBIST session scheduler: FSM state encoding and table entry layout.
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CLR,
        RUN,
        CHECK,
        FIN
    } lbist_state_t;

    typedef struct packed {
        logic [15:0] pat;
        logic [15:0] depth;
        logic [31:0] sig;
    } lbist_entry_t;

endpackage

// File: rtl/lbist_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next pending session.
module lbist_prio_enc #(
    parameter int NSES = 4
) (
    input  logic [NSES-1:0]         req,
    output logic [$clog2(NSES)-1:0] idx
);
    localparam int IW = $clog2(NSES);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int unsigned i = NSES; i > 0; i--) begin
            if (req[i-1]) idx = IW'(i - 1);
        end
    end

endmodule

// File: rtl/lbist_sched.sv
// LBIST session scheduler: runs enabled table entries in index order on one core.
// Optional watchdog per session enabled by defining LBIST_SCHED_TIMEOUT_EN.
module lbist_sched
    import lbist_pkg::*;
#(
    parameter int NSES = 4,
    parameter int TOW  = 24
) (
    input  logic                    mclk,
    input  logic                    srst,
    input  logic                    tbl_we,
    input  logic [$clog2(NSES)-1:0] tbl_idx,
    input  logic [15:0]             tbl_pat,
    input  logic [15:0]             tbl_depth,
    input  logic [31:0]             tbl_sig,
    input  logic                    sched_start,
    input  logic                    sched_abort,
    input  logic [NSES-1:0]         sched_mask,
    output logic                    core_srst,
    output logic                    lbist_start,
    output logic [15:0]             cfg_lbist_pat,
    output logic [15:0]             cfg_chain_depth,
    input  logic                    lbist_done,
    input  logic [31:0]             lbist_sig,
    output logic                    sched_busy,
    output logic                    sched_done,
    output logic [NSES-1:0]         sess_pass,
    output logic [NSES-1:0]         sess_fail,
    output logic [NSES-1:0]         sess_to,
    output logic [$clog2(NSES)-1:0] cur_idx
);
    if (NSES < 2 || NSES > 8 || TOW < 2) begin : g_cfg_check
        $error("lbist_sched: unsupported NSES/TOW");
    end

    lbist_state_t           state_q, state_nxt;
    lbist_entry_t           tbl [NSES];
    logic [NSES-1:0]        pend_q, pend_clr, cur_oh;
    logic [$clog2(NSES)-1:0] enc_idx;
    logic [31:0]            sig_q;
    logic                   kill_q, empty_done_q;
    logic                   start_any, abort_hit, to_hit, to_fire;

    lbist_prio_enc #(.NSES(NSES)) u_prio (
        .req (pend_q),
        .idx (enc_idx)
    );

    assign start_any = (state_q == IDLE) && sched_start;
    assign abort_hit = sched_abort && (state_q inside {SEL, CLR, RUN, CHECK});
    assign to_fire   = (state_q == RUN) && !lbist_done && !sched_abort && to_hit;

    always_ff @(posedge mclk) begin
        if (srst) state_q <= IDLE;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt   = state_q;
        lbist_start = 1'b0;
        core_srst   = kill_q;
        sched_busy  = (state_q != IDLE);
        sched_done  = empty_done_q;
        cur_oh      = '0;
        cur_oh[cur_idx] = 1'b1;
        pend_clr    = pend_q & ~cur_oh;
        case (state_q)
            IDLE:  if (sched_start && (sched_mask != '0)) state_nxt = SEL;
            SEL:   state_nxt = CLR;
            CLR: begin
                core_srst = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                lbist_start = 1'b1;
                if (lbist_done)   state_nxt = CHECK;
                else if (to_hit)  state_nxt = (pend_clr != '0) ? SEL : FIN;
            end
            CHECK: state_nxt = (pend_clr != '0) ? SEL : FIN;
            FIN: begin
                sched_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = FIN;
    end

    always_ff @(posedge mclk) begin
        if (srst) begin
            for (int unsigned i = 0; i < NSES; i++) tbl[i] <= '0;
            pend_q          <= '0;
            sess_pass       <= '0;
            sess_fail       <= '0;
            cur_idx         <= '0;
            cfg_lbist_pat   <= '0;
            cfg_chain_depth <= '0;
            sig_q           <= '0;
            kill_q          <= 1'b0;
            empty_done_q    <= 1'b0;
        end else begin
            kill_q       <= abort_hit || to_fire;
            empty_done_q <= start_any && (sched_mask == '0);
            if (state_q == IDLE && tbl_we)
                tbl[tbl_idx] <= '{pat: tbl_pat, depth: tbl_depth, sig: tbl_sig};
            if (start_any) begin
                sess_pass <= '0;
                sess_fail <= '0;
                pend_q    <= sched_mask;
            end
            // Abort drops the in-flight session without recording a result.
            if (abort_hit) begin
                pend_q <= '0;
            end else begin
                case (state_q)
                    SEL: begin
                        cur_idx         <= enc_idx;
                        cfg_lbist_pat   <= tbl[enc_idx].pat;
                        cfg_chain_depth <= tbl[enc_idx].depth;
                    end
                    RUN: begin
                        if (lbist_done) begin
                            sig_q <= lbist_sig;
                        end else if (to_fire) begin
                            sess_fail[cur_idx] <= 1'b1;
                            pend_q             <= pend_clr;
                        end
                    end
                    CHECK: begin
                        pend_q <= pend_clr;
                        if (sig_q == tbl[cur_idx].sig) sess_pass[cur_idx] <= 1'b1;
                        else                           sess_fail[cur_idx] <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LBIST_SCHED_TIMEOUT_EN
    logic [TOW-1:0] wdog_q, wdog_inc;
    logic [NSES-1:0] to_q;

    // Fires on the RUN cycle whose increment brings the counter to all-ones.
    assign wdog_inc = wdog_q + 1'b1;
    assign to_hit   = &wdog_inc;
    assign sess_to  = to_q;

    always_ff @(posedge mclk) begin
        if (srst) begin
            wdog_q <= '0;
            to_q   <= '0;
        end else begin
            if (state_q == CLR)      wdog_q <= '0;
            else if (state_q == RUN) wdog_q <= wdog_inc;
            if (start_any)           to_q <= '0;
            else if (to_fire)        to_q[cur_idx] <= 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign sess_to = '0;
`endif

endmodule

// File: tb/tb_lbist_sched.sv
// Directed self-checking bench for lbist_sched with a 2-cycle-latency core model.
module tb_lbist_sched;
    localparam int NSES = 4;

    logic        mclk = 1'b0;
    logic        srst, tbl_we, sched_start, sched_abort, lbist_done;
    logic [1:0]  tbl_idx, cur_idx;
    logic [15:0] tbl_pat, tbl_depth, cfg_lbist_pat, cfg_chain_depth;
    logic [31:0] tbl_sig, lbist_sig;
    logic [3:0]  sched_mask, sess_pass, sess_fail, sess_to;
    logic        core_srst, lbist_start, sched_busy, sched_done;

    always #5 mclk = ~mclk;

    lbist_sched #(.NSES(NSES), .TOW(4)) dut (
        .mclk(mclk), .srst(srst), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
        .tbl_pat(tbl_pat), .tbl_depth(tbl_depth), .tbl_sig(tbl_sig),
        .sched_start(sched_start), .sched_abort(sched_abort), .sched_mask(sched_mask),
        .core_srst(core_srst), .lbist_start(lbist_start),
        .cfg_lbist_pat(cfg_lbist_pat), .cfg_chain_depth(cfg_chain_depth),
        .lbist_done(lbist_done), .lbist_sig(lbist_sig),
        .sched_busy(sched_busy), .sched_done(sched_done),
        .sess_pass(sess_pass), .sess_fail(sess_fail), .sess_to(sess_to),
        .cur_idx(cur_idx)
    );

    // Core model: done two cycles after lbist_start rises, signature per session.
    logic [31:0] resp [NSES];
    logic        core_hang = 1'b0;
    int          cnt = 0;
    always @(posedge mclk) begin
        if (!lbist_start) cnt <= 0;
        else if (cnt < 3) cnt <= cnt + 1;
    end
    assign lbist_done = lbist_start && !core_hang && (cnt == 2);
    assign lbist_sig  = resp[cur_idx];

    int          order[$];
    logic [15:0] last_pat = '0, last_depth = '0;
    int          done_cnt = 0, srst_cyc = 0, run_cyc = 0;
    logic        busy_seen = 1'b0, prev_start = 1'b0;
    always @(negedge mclk) begin
        if (lbist_start && !prev_start) begin
            order.push_back(int'(cur_idx));
            last_pat   = cfg_lbist_pat;
            last_depth = cfg_chain_depth;
        end
        prev_start = lbist_start;
        if (sched_done)  done_cnt++;
        if (core_srst)   srst_cyc++;
        if (lbist_start) run_cyc++;
        if (sched_busy)  busy_seen = 1'b1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge mclk);
    endtask

    task automatic wr(input logic [1:0] i, input logic [15:0] p, input logic [15:0] d, input logic [31:0] s);
        tbl_we = 1'b1; tbl_idx = i; tbl_pat = p; tbl_depth = d; tbl_sig = s;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic start(input logic [3:0] m);
        sched_mask = m; sched_start = 1'b1;
        tick();
        sched_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sched_done) begin ok = 1'b1; break; end
            tick();
        end
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_run(input string tag, input logic [1:0] idx);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (lbist_start && cur_idx == idx) begin ok = 1'b1; break; end
            tick();
        end
        chk({tag, "_run_seen"}, 64'(ok), 64'd1);
    endtask

    initial begin
        srst = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_pat = '0; tbl_depth = '0; tbl_sig = '0;
        sched_start = 1'b0; sched_abort = 1'b0; sched_mask = '0;
        resp[0] = 32'hA5A5_0001; resp[1] = 32'h1111_1111;
        resp[2] = 32'h2222_2222; resp[3] = 32'hDEAD_BEEF;
        repeat (3) tick();
        chk("rst_busy", 64'(sched_busy), 64'd0);
        chk("rst_done", 64'(sched_done), 64'd0);
        chk("rst_start", 64'(lbist_start), 64'd0);
        chk("rst_csrst", 64'(core_srst), 64'd0);
        chk("rst_status", {52'd0, sess_pass, sess_fail, sess_to}, 64'd0);
        chk("rst_cfg", {30'd0, cur_idx, cfg_lbist_pat, cfg_chain_depth}, 64'd0);
        srst = 1'b0;
        tick();
        wr(2'd0, 16'd4, 16'd8, 32'hA5A5_0001);
        wr(2'd1, 16'd1, 16'd2, 32'h1111_1111);
        wr(2'd2, 16'd3, 16'd4, 32'h2222_2222);
        wr(2'd3, 16'd5, 16'd6, 32'h3333_3333);

        // single session, matching signature
        order.delete(); done_cnt = 0; srst_cyc = 0;
        start(4'b0001);
        wait_done("t1");
        tick();
        chk("t1_pass", 64'(sess_pass), 64'b0001);
        chk("t1_fail", 64'(sess_fail), 64'b0000);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_pat", 64'(last_pat), 64'd4);
        chk("t1_depth", 64'(last_depth), 64'd8);
        chk("t1_csrst_cyc", 64'(srst_cyc), 64'd1);
        chk("t1_busy", 64'(sched_busy), 64'd0);

        // two sessions, second mismatches
        order.delete();
        start(4'b1010);
        wait_done("t2");
        tick();
        chk("t2_order_n", 64'(order.size()), 64'd2);
        chk("t2_order0", 64'(order.size() > 0 ? order[0] : -1), 64'd1);
        chk("t2_order1", 64'(order.size() > 1 ? order[1] : -1), 64'd3);
        chk("t2_pass", 64'(sess_pass), 64'b0010);
        chk("t2_fail", 64'(sess_fail), 64'b1000);

        // empty mask
        busy_seen = 1'b0; done_cnt = 0;
        start(4'b0000);
        chk("t3_done", 64'(sched_done), 64'd1);
        chk("t3_status", {56'd0, sess_pass, sess_fail}, 64'd0);
        tick();
        chk("t3_done_off", 64'(sched_done), 64'd0);
        chk("t3_busy_seen", 64'(busy_seen), 64'd0);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);

        // abort while session 2 runs
        start(4'b0111);
        wait_run("t4", 2'd2);
        sched_abort = 1'b1;
        tick();
        sched_abort = 1'b0;
        chk("t4_csrst", 64'(core_srst), 64'd1);
        chk("t4_fin_done", 64'(sched_done), 64'd1);
        chk("t4_start_off", 64'(lbist_start), 64'd0);
        tick();
        chk("t4_idle", {62'd0, sched_busy, core_srst}, 64'd0);
        chk("t4_pass", 64'(sess_pass), 64'b0011);
        chk("t4_fail", 64'(sess_fail), 64'b0000);

        // table write while busy is dropped
        start(4'b0001);
        chk("t5_busy", 64'(sched_busy), 64'd1);
        wr(2'd0, 16'd9, 16'd9, 32'hFFFF_FFFF);
        wait_done("t5a");
        tick();
        chk("t5a_pass", 64'(sess_pass), 64'b0001);
        start(4'b0001);
        wait_done("t5b");
        tick();
        chk("t5b_pass", 64'(sess_pass), 64'b0001);
        chk("t5b_pat", 64'(last_pat), 64'd4);

`ifdef LBIST_SCHED_TIMEOUT_EN
        // watchdog with a core that never finishes
        core_hang = 1'b1; run_cyc = 0;
        start(4'b0001);
        wait_done("t6");
        tick();
        chk("t6_to", 64'(sess_to), 64'b0001);
        chk("t6_fail", 64'(sess_fail), 64'b0001);
        chk("t6_pass", 64'(sess_pass), 64'b0000);
        chk("t6_run_cyc", 64'(run_cyc), 64'd15);
        core_hang = 1'b0;
`endif

        // reset in the middle of a session
        start(4'b0001);
        wait_run("t7", 2'd0);
        done_cnt = 0;
        srst = 1'b1;
        tick();
        chk("t7_ctl", {60'd0, lbist_start, sched_busy, sched_done, core_srst}, 64'd0);
        chk("t7_status", {52'd0, sess_pass, sess_fail, sess_to}, 64'd0);
        chk("t7_cfg", {30'd0, cur_idx, cfg_lbist_pat, cfg_chain_depth}, 64'd0);
        srst = 1'b0;
        repeat (5) tick();
        chk("t7_no_done", 64'(done_cnt), 64'd0);
        start(4'b0001);
        wait_done("t7b");
        tick();
        chk("t7b_fail", 64'(sess_fail), 64'b0001);
        chk("t7b_pat", 64'(last_pat), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
